// File: rtl/game_step_scheduler_pkg.sv
// game_pkg: shared definitions for the snake-game step scheduler slice.
//   gameState_t           - scheduler FSM state encoding (IDLE..HALT)
//   DEFAULT_MAX_DIVIDE    - ticks per step at the slowest speed
//   WATCHDOG_CYCLES       - default cycle budget for any stage wait state
//   DEFAULT_OVERRUN_WIDTH - default width of the overrun counter
package game_pkg;

    localparam int DEFAULT_MAX_DIVIDE    = 4;
    localparam int WATCHDOG_CYCLES       = 1024;
    localparam int DEFAULT_OVERRUN_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LATCH   = 3'd1,
        MOVE    = 3'd2,
        COLLIDE = 3'd3,
        RENDER  = 3'd4,
        HALT    = 3'd5
    } gameState_t;

endpackage

// File: rtl/game_step_scheduler_if.sv
// game_step_scheduler_if: control bus between the step scheduler, the clock
// divider and the game datapath stages.
//   TickStrobe, SpeedLevel, Pause, Restart  - game control inputs
//   StepDone, CollisionHit                  - stage completion from datapath
//   LatchInput, MoveStart, CollideStart,
//   RenderStart                             - 1-cycle stage start pulses
//   Busy, GameOver, Fault, OverrunCount     - status
//
// Handshake: each start pulse is high for exactly one cycle, aligned with the
// first cycle of the stage. The stage answers with a 1-cycle StepDone no
// earlier than the second cycle of the stage; a StepDone seen in the same
// cycle as the start pulse is ignored. CollisionHit is only meaningful
// alongside StepDone during the collision stage. LatchInput needs no answer.
interface game_step_scheduler_if #(
    parameter int OverrunWidth = 8
) ();

    logic                    TickStrobe;
    logic [1:0]              SpeedLevel;
    logic                    Pause;
    logic                    Restart;
    logic                    StepDone;
    logic                    CollisionHit;
    logic                    LatchInput;
    logic                    MoveStart;
    logic                    CollideStart;
    logic                    RenderStart;
    logic                    Busy;
    logic                    GameOver;
    logic                    Fault;
    logic [OverrunWidth-1:0] OverrunCount;

    // Scheduler side.
    modport master (
        input  TickStrobe, SpeedLevel, Pause, Restart, StepDone, CollisionHit,
        output LatchInput, MoveStart, CollideStart, RenderStart,
        output Busy, GameOver, Fault, OverrunCount
    );

    // Divider / datapath side.
    modport slave (
        output TickStrobe, SpeedLevel, Pause, Restart, StepDone, CollisionHit,
        input  LatchInput, MoveStart, CollideStart, RenderStart,
        input  Busy, GameOver, Fault, OverrunCount
    );

endinterface

// File: rtl/game_step_scheduler_tick_prescaler.sv
// tick_prescaler: counts game ticks and flags when a step is due.
//   MasterClock - system clock
//   Reset       - asynchronous active-high reset
//   TickStrobe  - 1-cycle game tick
//   CountEnable - ticks are only counted while high
//   Clear       - synchronous counter clear; also suppresses Due
//   SpeedLevel  - divisor = MaxDivide - SpeedLevel, minimum 1
//   Due         - 1-cycle step-due pulse (combinational from the counted tick)
module tick_prescaler
    import game_pkg::*;
#(
    parameter int MaxDivide = DEFAULT_MAX_DIVIDE
) (
    input  logic       MasterClock,
    input  logic       Reset,
    input  logic       TickStrobe,
    input  logic       CountEnable,
    input  logic       Clear,
    input  logic [1:0] SpeedLevel,
    output logic       Due
);

    localparam int CountWidth = $clog2(MaxDivide + 1);

    logic [CountWidth-1:0] divideCount;
    logic [CountWidth-1:0] lastCount;
    logic                  countHit;
    logic                  countTick;

    // Terminal count is divisor-1, with the divisor clamped to at least 1.
    // SpeedLevel is evaluated on the tick that decides whether a step issues.
    always_comb begin
        lastCount = '0;
        if (MaxDivide - int'(SpeedLevel) > 1) begin
            lastCount = CountWidth'(MaxDivide - int'(SpeedLevel) - 1);
        end
    end

    // >= rather than == so a speed-up mid-count cannot skip the terminal value.
    assign countHit  = (divideCount >= lastCount);
    assign countTick = TickStrobe && CountEnable;
    assign Due       = countTick && countHit && !Clear;

    always_ff @(posedge MasterClock or posedge Reset) begin
        if (Reset) begin
            divideCount <= '0;
        end else if (Clear) begin
            divideCount <= '0;
        end else if (countTick) begin
            divideCount <= countHit ? '0 : divideCount + CountWidth'(1);
        end
    end

endmodule

// File: rtl/game_step_scheduler.sv
// game_step_scheduler: issues one snake-game update every N game ticks and
// walks the datapath through latch -> move -> collide -> render.
//   MasterClock - system clock, all logic on posedge
//   Reset       - asynchronous active-high reset, clears all state
//   Bus         - control bus (master side), see game_step_scheduler_if
//   DebugState  - current FSM state
// A due step that arrives while a step is running is held as one pending
// step and counted in OverrunCount. A stage that never answers is abandoned
// after WatchdogCycles cycles and flags the sticky Fault.
module game_step_scheduler
    import game_pkg::*;
#(
    parameter int MaxDivide      = DEFAULT_MAX_DIVIDE,
    parameter int WatchdogCycles = WATCHDOG_CYCLES,
    parameter int OverrunWidth   = DEFAULT_OVERRUN_WIDTH
) (
    input  logic                  MasterClock,
    input  logic                  Reset,
    game_step_scheduler_if.master Bus,
    output gameState_t            DebugState
);

    localparam int WdWidth = (WatchdogCycles > 2) ? $clog2(WatchdogCycles) : 1;
    localparam logic [WdWidth-1:0] WdLast = WdWidth'(WatchdogCycles - 1);

    gameState_t              state;
    logic                    pending;
    logic [WdWidth-1:0]      wdCount;
    logic                    latchInput;
    logic                    moveStart;
    logic                    collideStart;
    logic                    renderStart;
    logic                    fault;
    logic [OverrunWidth-1:0] overrunCount;

    logic due;
    logic countEnable;
    logic firstCycle;
    logic doneAccepted;
    logic wdExpired;
    logic inWaitState;
    logic overrunFull;

    assign countEnable = !Bus.Pause && (state != HALT);

    tick_prescaler #(
        .MaxDivide(MaxDivide)
    ) uPrescaler (
        .MasterClock(MasterClock),
        .Reset      (Reset),
        .TickStrobe (Bus.TickStrobe),
        .CountEnable(countEnable),
        .Clear      (Bus.Restart),
        .SpeedLevel (Bus.SpeedLevel),
        .Due        (due)
    );

    // The start pulses are registered with the state, so a start pulse being
    // high marks the first cycle of a wait state, where StepDone is ignored.
    assign firstCycle   = moveStart || collideStart || renderStart;
    assign doneAccepted = Bus.StepDone && !firstCycle;
    assign wdExpired    = (wdCount == WdLast);
    assign inWaitState  = (state == MOVE) || (state == COLLIDE) || (state == RENDER);
    assign overrunFull  = &overrunCount;

    always_ff @(posedge MasterClock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            pending      <= 1'b0;
            wdCount      <= '0;
            latchInput   <= 1'b0;
            moveStart    <= 1'b0;
            collideStart <= 1'b0;
            renderStart  <= 1'b0;
            fault        <= 1'b0;
            overrunCount <= '0;
        end else begin
            latchInput   <= 1'b0;
            moveStart    <= 1'b0;
            collideStart <= 1'b0;
            renderStart  <= 1'b0;
            wdCount      <= inWaitState ? wdCount + WdWidth'(1) : '0;

            // Due is already suppressed by Restart inside the prescaler.
            if (Bus.Restart) begin
                fault        <= 1'b0;
                overrunCount <= '0;
            end else if (due && (state != IDLE) && !overrunFull) begin
                overrunCount <= overrunCount + OverrunWidth'(1);
            end
            if (due && (state != IDLE)) begin
                pending <= 1'b1;
            end

            // Stage transitions; StepDone takes priority over watchdog expiry.
            case (state)
                IDLE: begin
                    if ((due || pending) && !Bus.Pause) begin
                        state      <= LATCH;
                        latchInput <= 1'b1;
                        pending    <= 1'b0;
                    end
                end
                LATCH: begin
                    state     <= MOVE;
                    moveStart <= 1'b1;
                    wdCount   <= '0;
                end
                MOVE: begin
                    if (doneAccepted) begin
                        state        <= COLLIDE;
                        collideStart <= 1'b1;
                        wdCount      <= '0;
                    end else if (wdExpired) begin
                        state   <= IDLE;
                        fault   <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                COLLIDE: begin
                    if (doneAccepted) begin
                        if (Bus.CollisionHit) begin
                            state   <= HALT;
                            pending <= 1'b0;
                        end else begin
                            state       <= RENDER;
                            renderStart <= 1'b1;
                            wdCount     <= '0;
                        end
                    end else if (wdExpired) begin
                        state   <= IDLE;
                        fault   <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                RENDER: begin
                    if (doneAccepted) begin
                        state <= IDLE;
                    end else if (wdExpired) begin
                        state   <= IDLE;
                        fault   <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                HALT: begin
                    pending <= 1'b0;
                    if (Bus.Restart) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Bus.LatchInput   = latchInput;
    assign Bus.MoveStart    = moveStart;
    assign Bus.CollideStart = collideStart;
    assign Bus.RenderStart  = renderStart;
    assign Bus.Busy         = (state != IDLE) && (state != HALT);
    assign Bus.GameOver     = (state == HALT);
    assign Bus.Fault        = fault;
    assign Bus.OverrunCount = overrunCount;
    assign DebugState       = state;

endmodule
